collective_sequencer: RTL

COLLECTIVE_SEQUENCER -- requirements
Module: collective_sequencer

---
 rtl/collective_pkg.sv | 26 ++
 rtl/chan_out_slot.sv | 59 +++++
 rtl/collective_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/collective_pkg.sv
// Shared types and constants for the collective sequencer: collective modes,
// sequencer states and the command opcodes sent to each channel.
package collective_pkg;

  typedef enum logic [1:0] {
    MODE_REDUCE    = 2'd0,
    MODE_ALLREDUCE = 2'd1,
    MODE_BARRIER   = 2'd2
  } mode_e;

  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HDR,
    S_LEN,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [7:0] OP_REDUCE  = 8'd0;
  localparam logic [7:0] OP_BCAST   = 8'd1;
  localparam logic [7:0] OP_BARRIER = 8'd2;

endpackage

// File: rtl/chan_out_slot.sv
// One channel's command output register: odata/ovalid plus the sticky
// "accepted" bit used by the sequencer to detect phase completion.
module chan_out_slot #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] odata_o,
  output logic         ovalid_o,
  output logic         acc_o
);

  logic [W-1:0] odata_q, odata_d;
  logic         ovalid_q, ovalid_d;
  logic         acc_q, acc_d;

  always_comb begin
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    acc_d    = acc_q;
    if (load_i) begin
      // A disabled channel is loaded with zero so it never shows a command.
      odata_d  = en_i ? data_i : '0;
      ovalid_d = en_i;
      acc_d    = 1'b0;
    end else if (clear_i) begin
      odata_d  = '0;
      ovalid_d = 1'b0;
      acc_d    = 1'b0;
    end else if (ovalid_q && ready_i) begin
      ovalid_d = 1'b0;
      acc_d    = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      acc_q    <= acc_d;
    end
  end

  assign odata_o  = odata_q;
  assign ovalid_o = ovalid_q;
  assign acc_o    = acc_q;

endmodule

// File: rtl/collective_sequencer.sv
// Collective sequencer: waits for all enabled channels, then issues a header
// (opcode) and a length command per phase, with a one-cycle gap between phases.
module collective_sequencer
  import collective_pkg::*;
#(
  parameter int X = 3,
  parameter int W = 128,
  parameter int D = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [X-1:0]   mask,
  input  logic [W*X-1:0] idata,
  input  logic [X-1:0]   ivalid,
  output logic [W*X-1:0] odata,
  output logic [X-1:0]   ovalid,
  input  logic [X-1:0]   oready,
  output logic           busy,
  output logic           done,
  output logic           phase
);

  localparam logic [W-1:0] BYTES_PER_CH = W'(64'(W) * (64'd1 << D) / 64'd8);
  localparam logic [63:0]  MAX_LEN      = 64'(X) * 64'(W) * (64'd1 << D) / 64'd8;

  if (W < 64) begin : g_len_chk
    if ((MAX_LEN >> W) != 64'd0) begin : g_len_overflow
      $error("collective_sequencer: X*W*2^D/8 does not fit in W bits");
    end
  end

  state_e       state_q, state_d;
  mode_e        mode_q, mode_d;
  logic [X-1:0] mask_q, mask_d;
  logic [W-1:0] len_q, len_d;
  logic         phase_q, phase_d;

  logic         slot_load, slot_clear;
  logic [W-1:0] slot_data, opcode;
  logic [X-1:0] slot_valid, slot_acc;
  logic [W-1:0] slot_odata [X];
  logic         all_acc;
  logic         unused_idata;

  assign unused_idata = ^idata;

  always_comb begin
    case (mode_q)
      MODE_BARRIER:   opcode = W'(OP_BARRIER);
      MODE_ALLREDUCE: opcode = phase_q ? W'(OP_BCAST) : W'(OP_REDUCE);
      default:        opcode = W'(OP_REDUCE);
    endcase
  end

  // Counts a channel accepting on this very edge as already done.
  assign all_acc = ((slot_acc | (slot_valid & oready)) & mask_q) == mask_q;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    len_d      = len_q;
    phase_d    = phase_q;
    slot_load  = 1'b0;
    slot_clear = 1'b0;
    slot_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (start && (mask != '0) && (mode != MODE_ILLEGAL)) begin
          mode_d  = mode_e'(mode);
          mask_d  = mask;
          len_d   = W'($countones(mask)) * BYTES_PER_CH;
          phase_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if ((ivalid & mask_q) == mask_q) begin
          slot_load = 1'b1;
          slot_data = opcode;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (all_acc) begin
          if (mode_q == MODE_BARRIER) begin
            slot_clear = 1'b1;
            state_d    = S_GAP;
          end else begin
            slot_load = 1'b1;
            slot_data = len_q;
            state_d   = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (all_acc) begin
          slot_clear = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (mode_q == MODE_ALLREDUCE && !phase_q) begin
          phase_d = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_REDUCE;
      mask_q  <= '0;
      len_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      phase_q <= phase_d;
    end
  end

  for (genvar i = 0; i < X; i++) begin : g_slot
    chan_out_slot #(.W(W)) u_slot (
      .clk      (clock),
      .rst_n    (reset),
      .en_i     (mask_q[i]),
      .load_i   (slot_load),
      .clear_i  (slot_clear),
      .data_i   (slot_data),
      .ready_i  (oready[i]),
      .odata_o  (slot_odata[i]),
      .ovalid_o (slot_valid[i]),
      .acc_o    (slot_acc[i])
    );
  end

  always_comb begin
    odata = '0;
    for (int i = 0; i < X; i++) begin
      odata[W*i +: W] = slot_odata[i];
    end
  end

  assign ovalid = slot_valid;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign phase  = phase_q;

endmodule
